regi_bank_ctrl: RTL and testbench

Write-port controller and arbiter for a bank of 32-bit registers. Up to NREQ requesters contend for the single write port; a registered round-robin arbiter grants one at a time, and the grantee's data is committed to the addressed register. A registered read port returns any register's contents. The block sits between datapath stages and the shared register bank, replacing the free-running load of a plain register with arbitrated, addressed updates.

---
 rtl/regi_bank_pkg.sv | 31 +++
 rtl/regi_bank_ctrl_rr_arbiter.sv | 53 +++++
 rtl/regi_bank_ctrl.sv | 165 ++++++++++++++++
 tb/tb_regi_bank_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regi_bank_pkg.sv
// ---------------------------------------------------------------------------
// regi_bank_pkg
// Shared definitions for the arbitrated register-bank write controller.
//   DW_DEFAULT    : default data width of a bank register
//   MAX_REQ       : widest requester vector onehot_to_idx can decode
//   state_t       : controller FSM states (IDLE, GRANT)
//   onehot_to_idx : index of the set bit of a one-hot vector (0 if none)
// ---------------------------------------------------------------------------
package regi_bank_pkg;

    localparam int DW_DEFAULT = 32;
    localparam int MAX_REQ    = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Callers zero-extend narrower vectors up to MAX_REQ bits.
    function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/regi_bank_ctrl_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. Searches req starting at ptr and wrapping
// past NREQ-1 back to 0; the first set bit wins.
// Ports:
//   req [NREQ-1:0] : request vector
//   ptr [PW-1:0]   : highest-priority requester for this pick
//   win [NREQ-1:0] : one-hot winner, all-zero when req is zero
//   idx [PW-1:0]   : index of the winner (0 when req is zero)
// ---------------------------------------------------------------------------
module rr_arbiter
    import regi_bank_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [PW-1:0]   idx
);

    logic                   found;
    logic [MAX_REQ-1:0]     win_ext;

    // Walk the requesters in priority order ptr, ptr+1, ... with wrap,
    // latching only the first one that is asking.
    always_comb begin : pick
        int j;
        j     = 0;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!found && req[j]) begin
                win[j] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        win_ext = '0;
        for (int i = 0; i < NREQ; i++) begin
            win_ext[i] = win[i];
        end
        idx = PW'(onehot_to_idx(win_ext));
    end

endmodule

// File: rtl/regi_bank_ctrl.sv
// ---------------------------------------------------------------------------
// regi_bank_ctrl
// Write-port controller for a bank of NREG registers. NREQ requesters share
// one write port through a registered round-robin arbiter. A grant lasts one
// cycle, during which the grantee's data is committed to its addressed
// register (if it still requests and the address is in range). A registered
// read port returns bank[rd_addr] with read-before-write semantics.
//
// Optional feature macro: REGI_BANK_LOCK_EN
//   When defined, a lock input lets the current grantee keep the grant and
//   write once per cycle for as long as it holds both lock and req.
//
// Ports:
//   clk     : clock, rising edge
//   r       : asynchronous active-low reset
//   req     : per-requester write request (level)
//   wr_addr : packed per-requester target address (slice i = requester i)
//   wr_data : packed per-requester write data
//   lock    : per-requester grant hold (REGI_BANK_LOCK_EN only)
//   gnt     : registered one-hot grant, zero when idle
//   busy    : high while in GRANT
//   rd_addr : read address
//   rd_data : registered read data, zero for out-of-range addresses
// ---------------------------------------------------------------------------
module regi_bank_ctrl
    import regi_bank_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int NREG = 8,
    parameter int AW   = $clog2(NREG),
    parameter int DW   = DW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 r,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   wr_addr,
    input  logic [NREQ*DW-1:0]   wr_data,
`ifdef REGI_BANK_LOCK_EN
    input  logic [NREQ-1:0]      lock,
`endif
    output logic [NREQ-1:0]      gnt,
    output logic                 busy,
    input  logic [AW-1:0]        rd_addr,
    output logic [DW-1:0]        rd_data
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = (NREG > 1) ? $clog2(NREG) : 1;

    state_t             state;
    state_t             state_nxt;
    logic [NREQ-1:0]    gnt_nxt;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      ptr_nxt;
    logic [PW-1:0]      widx;
    logic [PW-1:0]      widx_nxt;
    logic [PW-1:0]      widx_inc;

    logic [NREQ-1:0]    arb_win;
    logic [PW-1:0]      arb_idx;

    logic [AW-1:0]      cur_addr;
    logic [DW-1:0]      cur_data;
    logic               cur_req;
    logic               hold;
    logic               commit;

    logic [DW-1:0]      bank [NREG];

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req (req),
        .ptr (ptr),
        .win (arb_win),
        .idx (arb_idx)
    );

    // The grantee's index is registered alongside gnt so its address/data
    // slice can be selected directly during GRANT.
    assign cur_addr = wr_addr[widx*AW +: AW];
    assign cur_data = wr_data[widx*DW +: DW];
    assign cur_req  = req[widx];

    // A dropped request cancels the write; an out-of-range address
    // consumes the grant without touching the bank.
    assign commit = (state == GRANT) && cur_req && (int'(cur_addr) < NREG);

`ifdef REGI_BANK_LOCK_EN
    assign hold = (state == GRANT) && cur_req && lock[widx];
`else
    assign hold = 1'b0;
`endif

    assign widx_inc = (int'(widx) == NREQ - 1) ? '0 : widx + PW'(1);

    assign busy = (state == GRANT);

    // Next-state and grant logic. Only a grant that ends (no hold) moves the
    // round-robin pointer past the grantee.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        ptr_nxt   = ptr;
        widx_nxt  = widx;
        case (state)
            IDLE: begin
                if (|req) begin
                    gnt_nxt   = arb_win;
                    widx_nxt  = arb_idx;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!hold) begin
                    gnt_nxt   = '0;
                    ptr_nxt   = widx_inc;
                    state_nxt = IDLE;
                end
            end
            default: begin
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state <= IDLE;
            gnt   <= '0;
            ptr   <= '0;
            widx  <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            ptr   <= ptr_nxt;
            widx  <= widx_nxt;
        end
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            for (int i = 0; i < NREG; i++) begin
                bank[i] <= '0;
            end
        end else if (commit) begin
            bank[BW'(cur_addr)] <= cur_data;
        end
    end

    // Sampling the bank with a nonblocking read gives read-before-write on a
    // same-address collision.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            rd_data <= '0;
        end else if (int'(rd_addr) < NREG) begin
            rd_data <= bank[BW'(rd_addr)];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_regi_bank_ctrl.sv
// ---------------------------------------------------------------------------
// tb_regi_bank_ctrl
// Directed bench for regi_bank_ctrl (NREQ=4, NREG=8, AW=4 so that
// out-of-range addresses are representable). Inputs change on the falling
// edge; outputs are checked on the falling edge, away from the active edge.
// The lock scenario is built only when REGI_BANK_LOCK_EN is defined.
// ---------------------------------------------------------------------------
module tb_regi_bank_ctrl;

    localparam int NREQ = 4;
    localparam int NREG = 8;
    localparam int AW   = 4;
    localparam int DW   = 32;

    logic                 clk;
    logic                 r;
    logic [NREQ-1:0]      req;
    logic [NREQ*AW-1:0]   wr_addr;
    logic [NREQ*DW-1:0]   wr_data;
`ifdef REGI_BANK_LOCK_EN
    logic [NREQ-1:0]      lock;
`endif
    logic [NREQ-1:0]      gnt;
    logic                 busy;
    logic [AW-1:0]        rd_addr;
    logic [DW-1:0]        rd_data;

    int total;
    int bad;

    logic [3:0] rr_exp [8];

    regi_bank_ctrl #(
        .NREQ (NREQ),
        .NREG (NREG),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .clk     (clk),
        .r       (r),
        .req     (req),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
`ifdef REGI_BANK_LOCK_EN
        .lock    (lock),
`endif
        .gnt     (gnt),
        .busy    (busy),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Free-running clock: rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [3:0] rq, input logic [3:0] ra);
        req     = rq;
        rd_addr = ra;
    endtask

    task automatic setSlot(input int i, input logic [3:0] a, input logic [31:0] d);
        wr_addr[i*AW +: AW] = a;
        wr_data[i*DW +: DW] = d;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue a read with no requests pending and check the value one edge later.
    task automatic readCheck(input string tag, input logic [3:0] a, input logic [31:0] exp);
        applyStimulus(4'b0000, a);
        step();
        checkOutput(tag, rd_data, exp);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        r       = 1'b0;
        req     = '0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
`ifdef REGI_BANK_LOCK_EN
        lock    = '0;
`endif
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0000;
        rr_exp[2] = 4'b0010; rr_exp[3] = 4'b0000;
        rr_exp[4] = 4'b0100; rr_exp[5] = 4'b0000;
        rr_exp[6] = 4'b1000; rr_exp[7] = 4'b0000;

        $display("[TB] start");
        step();
        step();
        r = 1'b1;
        checkOutput("reset_gnt",  32'(gnt),  32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_rd",   rd_data,   32'h0);

        // Reset asserted while a write of 0x1234 to register 2 is granted.
        setSlot(0, 4'd2, 32'h0000_1234);
        applyStimulus(4'b0001, 4'd2);
        step();
        checkOutput("pre_rst_gnt",  32'(gnt),  32'h1);
        checkOutput("pre_rst_busy", 32'(busy), 32'h1);
        r = 1'b0;
        #1;
        checkOutput("rst_gnt",  32'(gnt),     32'h0);
        checkOutput("rst_busy", 32'(busy),    32'h0);
        checkOutput("rst_rd",   rd_data,      32'h0);
        checkOutput("rst_ptr",  32'(dut.ptr), 32'h0);
        applyStimulus(4'b0000, 4'd0);
        step();
        step();
        r = 1'b1;
        for (int i = 0; i < NREG; i++) begin
            readCheck($sformatf("rst_bank%0d", i), 4'(i), 32'h0);
        end

        // Single write from requester 1.
        setSlot(1, 4'd3, 32'hDEAD_BEEF);
        applyStimulus(4'b0010, 4'd3);
        step();
        checkOutput("single_gnt", 32'(gnt), 32'h2);
        step();
        checkOutput("single_release", 32'(gnt), 32'h0);
        applyStimulus(4'b0000, 4'd3);
        step();
        checkOutput("single_rd",  rd_data,      32'hDEAD_BEEF);
        checkOutput("single_ptr", 32'(dut.ptr), 32'h2);

        // Requester 3 write to register 5 brings the pointer back to 0.
        setSlot(3, 4'd5, 32'h3333_3333);
        applyStimulus(4'b1000, 4'd0);
        step();
        checkOutput("r3_gnt", 32'(gnt), 32'h8);
        step();
        checkOutput("r3_ptr", 32'(dut.ptr), 32'h0);

        // All four requesting: grants 0,1,2,3 on alternating cycles.
        setSlot(0, 4'd0, 32'h0000_00A0);
        setSlot(1, 4'd1, 32'h0000_00A1);
        setSlot(2, 4'd2, 32'h0000_00A2);
        setSlot(3, 4'd6, 32'h0000_00A3);
        applyStimulus(4'b1111, 4'd0);
        for (int c = 0; c < 8; c++) begin
            step();
            checkOutput($sformatf("rr_gnt_c%0d", c), 32'(gnt), 32'(rr_exp[c]));
        end
        applyStimulus(4'b0000, 4'd0);
        checkOutput("rr_ptr", 32'(dut.ptr), 32'h0);
        readCheck("rr_rd0", 4'd0, 32'h0000_00A0);
        readCheck("rr_rd1", 4'd1, 32'h0000_00A1);
        readCheck("rr_rd2", 4'd2, 32'h0000_00A2);
        readCheck("rr_rd6", 4'd6, 32'h0000_00A3);
        readCheck("rr_rd5", 4'd5, 32'h3333_3333);
        readCheck("rr_rd3", 4'd3, 32'hDEAD_BEEF);

        // Requester 2 drops its request during the grant: no write.
        setSlot(2, 4'd2, 32'hBAD0_BAD0);
        applyStimulus(4'b0100, 4'd0);
        step();
        checkOutput("cancel_gnt", 32'(gnt), 32'h4);
        applyStimulus(4'b0000, 4'd0);
        step();
        checkOutput("cancel_release", 32'(gnt), 32'h0);
        checkOutput("cancel_ptr", 32'(dut.ptr), 32'h3);
        readCheck("cancel_rd2", 4'd2, 32'h0000_00A2);

        // Requester 3 targets register 9: grant consumed, no write.
        setSlot(3, 4'd9, 32'hBAD9_BAD9);
        applyStimulus(4'b1000, 4'd0);
        step();
        checkOutput("oor_gnt", 32'(gnt), 32'h8);
        step();
        applyStimulus(4'b0000, 4'd0);
        checkOutput("oor_ptr", 32'(dut.ptr), 32'h0);
        readCheck("oor_rd1", 4'd1, 32'h0000_00A1);
        readCheck("oor_rd9", 4'd9, 32'h0);

        // Seed register 4 with 0xAA, then overwrite with 0x55 while reading it.
        setSlot(0, 4'd4, 32'h0000_00AA);
        applyStimulus(4'b0001, 4'd0);
        step();
        step();
        applyStimulus(4'b0000, 4'd4);
        step();
        checkOutput("coll_pre", rd_data, 32'h0000_00AA);
        setSlot(1, 4'd4, 32'h0000_0055);
        applyStimulus(4'b0010, 4'd4);
        step();
        checkOutput("coll_gnt", 32'(gnt), 32'h2);
        step();
        checkOutput("coll_same_edge", rd_data, 32'h0000_00AA);
        applyStimulus(4'b0000, 4'd4);
        step();
        checkOutput("coll_next_edge", rd_data, 32'h0000_0055);

`ifdef REGI_BANK_LOCK_EN
        // Pointer is 2: requester 0 wins over 1, then bursts three writes.
        setSlot(0, 4'd0, 32'h0000_00D0);
        setSlot(1, 4'd7, 32'h0000_00C1);
        lock = 4'b0001;
        applyStimulus(4'b0011, 4'd0);
        step();
        checkOutput("lock_gnt0", 32'(gnt), 32'h1);
        step();
        checkOutput("lock_gnt1", 32'(gnt), 32'h1);
        setSlot(0, 4'd1, 32'h0000_00D1);
        step();
        checkOutput("lock_gnt2", 32'(gnt), 32'h1);
        setSlot(0, 4'd2, 32'h0000_00D2);
        lock = 4'b0000;
        step();
        checkOutput("lock_release", 32'(gnt), 32'h0);
        checkOutput("lock_ptr", 32'(dut.ptr), 32'h1);
        applyStimulus(4'b0010, 4'd0);
        step();
        checkOutput("lock_next_gnt", 32'(gnt), 32'h2);
        step();
        applyStimulus(4'b0000, 4'd0);
        readCheck("lock_rd0", 4'd0, 32'h0000_00D0);
        readCheck("lock_rd1", 4'd1, 32'h0000_00D1);
        readCheck("lock_rd2", 4'd2, 32'h0000_00D2);
        readCheck("lock_rd7", 4'd7, 32'h0000_00C1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
